cg_domain_ctrl: RTL and testbench

Multi-domain clock-gate controller. It decides, per gated clock domain, when the clock-enable driving that domain's latch-based gating cell is asserted. Each domain's enable drops after a programmable idle interval and is restored on a busy indication or an explicit wake request, with a fixed settle window before the domain is reported awake. The block runs on the free-running core clock and sits between the domain activity sources and the gating cells.

---
 rtl/cg_domain_ctrl.sv | 125 ++++++++++++
 tb/tb_cg_domain_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cg_domain_ctrl.sv
// rtl/cg_domain_ctrl.sv - per-domain clock-gate enable controller (optional stats: CG_CTRL_STATS_EN)
module cg_domain_ctrl #(
    parameter int NUM_DOM    = 4,
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_DLY   = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [NUM_DOM-1:0]    dom_busy,
    input  logic [NUM_DOM-1:0]    dom_wake_req,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    input  logic                  cg_force_on,
`ifdef CG_CTRL_STATS_EN
    input  logic                  cg_stat_clr,
    output logic [NUM_DOM*16-1:0] cg_off_cnt,
`endif
    output logic [NUM_DOM-1:0]    dom_clk_en,
    output logic [NUM_DOM-1:0]    dom_wake_ack
);

    localparam int WW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
    localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_DLY - 1);

    typedef enum logic [1:0] {ST_ON, ST_IDLE, ST_OFF, ST_WAKE} state_t;

    state_t                state_q [NUM_DOM];
    state_t                state_d [NUM_DOM];
    logic [IDLE_CNT_W-1:0] cnt_q   [NUM_DOM];
    logic [IDLE_CNT_W-1:0] cnt_d   [NUM_DOM];
    logic [WW-1:0]         wcnt_q  [NUM_DOM];
    logic [WW-1:0]         wcnt_d  [NUM_DOM];
    logic [NUM_DOM-1:0]    act;
    logic [NUM_DOM-1:0]    gate_off;
    logic [NUM_DOM-1:0]    clk_en_q;
    logic [NUM_DOM-1:0]    ack_q;

    assign act = dom_busy | dom_wake_req | {NUM_DOM{cg_force_on}};

    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            wcnt_d[i]   = wcnt_q[i];
            gate_off[i] = 1'b0;
            case (state_q[i])
                ST_ON: begin
                    if (!act[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_IDLE: begin
                    // Activity is checked before the threshold so a late request keeps CE high.
                    if (act[i]) begin
                        state_d[i] = ST_ON;
                    end else if (cnt_q[i] >= idle_thresh) begin
                        state_d[i]  = ST_OFF;
                        gate_off[i] = 1'b1;
                    end else if (cnt_q[i] != '1) begin
                        cnt_d[i] = cnt_q[i] + IDLE_CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (act[i]) begin
                        state_d[i] = ST_WAKE;
                        wcnt_d[i]  = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (wcnt_q[i] == '0) begin
                        state_d[i] = ST_ON;
                    end else begin
                        wcnt_d[i] = wcnt_q[i] - WW'(1);
                    end
                end
                default: state_d[i] = ST_ON;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= ST_ON;
                cnt_q[i]   <= '0;
                wcnt_q[i]  <= '0;
            end
            clk_en_q <= '1;
            ack_q    <= '1;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                wcnt_q[i]   <= wcnt_d[i];
                clk_en_q[i] <= (state_d[i] != ST_OFF);
                ack_q[i]    <= (state_d[i] == ST_ON);
            end
        end
    end

    assign dom_clk_en   = clk_en_q;
    assign dom_wake_ack = ack_q;

`ifdef CG_CTRL_STATS_EN
    logic [15:0] off_cnt_q [NUM_DOM];

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < NUM_DOM; i++) off_cnt_q[i] <= '0;
        end else if (cg_stat_clr) begin
            for (int i = 0; i < NUM_DOM; i++) off_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                if (gate_off[i] && off_cnt_q[i] != 16'hFFFF) off_cnt_q[i] <= off_cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        cg_off_cnt = '0;
        for (int i = 0; i < NUM_DOM; i++) cg_off_cnt[i*16 +: 16] = off_cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_cg_domain_ctrl.sv
// tb/tb_cg_domain_ctrl.sv - directed scoreboard bench for cg_domain_ctrl
module tb_cg_domain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] busy = 4'h0;
    logic [3:0] wake = 4'h0;
    logic [7:0] thresh = 8'd3;
    logic       force_on = 1'b0;
    logic       stat_clr = 1'b0;
    logic [3:0] en;
    logic [3:0] ack;
`ifdef CG_CTRL_STATS_EN
    logic [63:0] offc;
`endif

    cg_domain_ctrl #(.NUM_DOM(4), .IDLE_CNT_W(8), .WAKE_DLY(2)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .dom_busy      (busy),
        .dom_wake_req  (wake),
        .idle_thresh   (thresh),
        .cg_force_on   (force_on),
`ifdef CG_CTRL_STATS_EN
        .cg_stat_clr   (stat_clr),
        .cg_off_cnt    (offc),
`endif
        .dom_clk_en    (en),
        .dom_wake_ack  (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] en;
        logic [3:0] ack;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   nstep = 0;

    // Inputs applied here are sampled at the next rising edge; expected outputs follow that edge.
    task automatic step(input logic r, input logic [3:0] b, input logic [3:0] w, input logic f,
                        input logic [7:0] th, input logic clr, input logic [3:0] een, input logic [3:0] eack);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        busy     = b;
        wake     = w;
        force_on = f;
        thresh   = th;
        stat_clr = clr;
        e.id  = nstep;
        e.en  = een;
        e.ack = eack;
        sb.push_back(e);
        nstep++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (en !== e.en || ack !== e.ack) begin
                    bad++;
                    $display("FAIL step%0d: en=%b ack=%b, expected en=%b ack=%b", e.id, en, ack, e.en, e.ack);
                end
            end
        end
    end

`ifdef CG_CTRL_STATS_EN
    task automatic chk_stat(input logic [15:0] exp_cnt);
        @(posedge clk);
        #2;
        total++;
        if (offc[15:0] !== exp_cnt) begin
            bad++;
            $display("FAIL off_cnt0: got %0d, expected %0d", offc[15:0], exp_cnt);
        end
    endtask

    task automatic gate_cycle_dom0(input logic clr_at_off);
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd0, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd0, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd0, 1'b0, 4'h1, 4'h1);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, clr_at_off, 4'h0, 4'h0);
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset held, then release: thresh 3 gates every domain after 1 + 3 + 1 edges.
        step(1'b0, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'hF, 4'hF);
        step(1'b0, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'hF, 4'hF);
        repeat (4) step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'hF, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'h0, 4'h0);

        // Wake request on domain 2 only; settle of two edges before ack.
        step(1'b1, 4'h0, 4'h4, 1'b0, 8'd3, 1'b0, 4'h4, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'h4, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'h4, 4'h4);
        repeat (4) step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'h4, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd3, 1'b0, 4'h0, 4'h0);

        // Race with thresh 0: busy returns exactly when IDLE would gate.
        step(1'b1, 4'h2, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h0);
        step(1'b1, 4'h2, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h0);
        step(1'b1, 4'h2, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h2);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h0);
        step(1'b1, 4'h2, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h2);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h2, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);

        // One-cycle force wakes every domain; thresh 1 then gates them again.
        step(1'b1, 4'h0, 4'h0, 1'b1, 8'd1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd1, 1'b0, 4'hF, 4'hF);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd1, 1'b0, 4'h0, 4'h0);

        // Lower thresh 200 -> 5 while domain 0 idle count is 50.
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd200, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd200, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd200, 1'b0, 4'h1, 4'h1);
        repeat (51) step(1'b1, 4'h0, 4'h0, 1'b0, 8'd200, 1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd5, 1'b0, 4'h0, 4'h0);

        // Reset asserted between edges while domain 0 is in WAKE.
        step(1'b1, 4'h1, 4'h0, 1'b0, 8'd5, 1'b0, 4'h1, 4'h0);
        @(negedge clk);
        busy = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (en !== 4'hF || ack !== 4'hF) begin
            bad++;
            $display("FAIL async_reset: en=%b ack=%b, expected en=1111 ack=1111", en, ack);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0, 8'd5, 1'b0, 4'hF, 4'hF);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd5, 1'b0, 4'hF, 4'h0);

`ifdef CG_CTRL_STATS_EN
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 4'h0);
        chk_stat(16'd0);
        repeat (3) gate_cycle_dom0(1'b0);
        chk_stat(16'd3);
        gate_cycle_dom0(1'b1);
        chk_stat(16'd0);
`endif

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
